tt_scan_capture: RTL and testbench

- Hardware counterpart of the exhaustive 3-input truth-table bench; it reads the table back instead of printing it.
- On `start`, walks the input vector `{A,B,C}` from 3'b000 to 3'b111, drives those inputs to a combinational function block (e.g. the mux-built function), and captures its output `F` into an 8-bit truth-table register.
- Compares the captured table against an expected table and reports pass/fail plus a mismatch count.
- Sits beside any 3-input function unit as a self-test / BIST engine.

---
 rtl/tt_scan_pkg.sv | 12 +
 rtl/tt_scan_capture_settle_timer.sv | 27 ++
 rtl/tt_scan_capture.sv | 96 +++++++++
 tb/tb_tt_scan_capture.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tt_scan_pkg.sv
// Shared types and sizes for the truth-table scan engine.
//   scan_state_t : controller states
//   NUM_VEC      : number of input vectors walked (2^VEC_W)
//   VEC_W        : width of the {A,B,C} vector / index
//   CNT_W        : width of the settle counter (SETTLE up to 15)
package tt_scan_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} scan_state_t;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;
  localparam int CNT_W   = 4;
endpackage

// File: rtl/tt_scan_capture_settle_timer.sv
// Settle timer: counts cycles the current vector has been held.
//   clk, rst_n : clock, async active-low reset
//   clr        : force count back to 0 (new scan accepted)
//   en         : count while the scan is driving vectors
//   expire     : high in the cycle where cnt == SETTLE (sample F now)
// The count wraps to 0 on the expire cycle, so each vector lasts SETTLE+1 cycles.
module settle_timer
  import tt_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == CNT_W'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr || (en && expire)) cnt <= '0;
    else if (en)                 cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/tt_scan_capture.sv
// Truth-table scan / BIST engine for a 3-input combinational function.
// On start it walks {A,B,C} 0..7, holds each vector SETTLE+1 cycles,
// samples F into tt[idx] and counts bits differing from the latched
// expected table.
//   clk, rst_n   : clock, async active-low reset
//   start        : begin a scan (accepted only in IDLE)
//   exp_tt       : expected table, latched on accepted start
//   A, B, C      : registered function inputs (A = MSB)
//   F            : function output, combinational from A/B/C
//   busy         : scan in progress (DRIVE and DONE states)
//   done         : one-cycle completion pulse
//   tt           : captured table, bit i = F at vector i
//   mismatch_cnt : number of differing bits (0..8)
//   pass         : mismatch_cnt == 0 for the last completed scan
module tt_scan_capture
  import tt_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp_tt,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic [3:0] mismatch_cnt,
  output logic       pass
);
  scan_state_t      state;
  logic [VEC_W-1:0] idx;
  logic [7:0]       exp_q;
  logic             expire;
  logic             accept;

  assign accept = (state == IDLE) && start;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (state == DRIVE),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      {A, B, C}    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      tt           <= 8'h00;
      mismatch_cnt <= 4'd0;
      exp_q        <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          exp_q        <= exp_tt;
          tt           <= 8'h00;
          mismatch_cnt <= 4'd0;
          pass         <= 1'b0;
          idx          <= '0;
          {A, B, C}    <= '0;
          busy         <= 1'b1;
          state        <= DRIVE;
        end
        DRIVE: if (expire) begin
          tt[idx] <= F;
          if (F != exp_q[idx]) mismatch_cnt <= mismatch_cnt + 4'd1;
          if (idx == VEC_W'(NUM_VEC - 1)) begin
            // vector stays at 7 after the scan
            state <= DONE;
          end else begin
            idx       <= idx + VEC_W'(1);
            {A, B, C} <= idx + VEC_W'(1);
          end
        end
        DONE: begin
          // count is final here, including the vector-7 update
          done  <= 1'b1;
          pass  <= (mismatch_cnt == 4'd0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_scan_capture.sv
// Bench: three engines (SETTLE = 1, 0, 3) beside a parity / stuck-at-0
// function model. A scoreboard queue receives the expected result when a
// scan is issued; a monitor checks it when done pulses.
module tb_tt_scan_capture;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      start;
  logic [7:0]      exp_tt;
  logic [2:0]      a, b, c, f, busy, done, pass;
  logic [2:0][7:0] tt;
  logic [2:0][3:0] mc;
  logic            fmode;          // 0: F = A^B^C, 1: F stuck at 0

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    int         inst;
    int         e0;
    int         lat;
    logic [7:0] tt;
    logic [3:0] mc;
    logic       pass;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int sv(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_dut
    assign f[i] = fmode ? 1'b0 : (a[i] ^ b[i] ^ c[i]);
    tt_scan_capture #(.SETTLE(sv(i))) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start[i]),
      .exp_tt       (exp_tt),
      .A            (a[i]),
      .B            (b[i]),
      .C            (c[i]),
      .F            (f[i]),
      .busy         (busy[i]),
      .done         (done[i]),
      .tt           (tt[i]),
      .mismatch_cnt (mc[i]),
      .pass         (pass[i])
    );
  end

  task automatic chk(input string n, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding scan
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (done[i]) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_done: inst %0d cycle %0d", i, cyc);
        end else begin
          e = q.pop_front();
          chk("done_inst", i, e.inst);
          chk("done_latency", cyc - e.e0, e.lat);
          chk("tt", int'(tt[i]), int'(e.tt));
          chk("mismatch_cnt", int'(mc[i]), int'(e.mc));
          chk("pass", int'(pass[i]), int'(e.pass));
        end
      end
    end
  end

  task automatic push(input int s, input logic [7:0] t, input logic [3:0] m, input logic p);
    exp_t x;
    x.inst = s; x.e0 = cyc + 1; x.lat = 8 * (sv(s) + 1) + 1;
    x.tt = t; x.mc = m; x.pass = p;
    q.push_back(x);
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin @(posedge clk); #2; w++; end
    chk("drain_timeout", (q.size() == 0) ? 1 : 0, 1);
    q.delete();
    repeat (2) @(posedge clk);
  endtask

  // full scan, optionally checking that each vector is held SETTLE+1 cycles
  task automatic run_scan(input int s, input logic [7:0] e, input logic [7:0] t,
                          input logic [3:0] m, input logic p, input bit walk);
    @(negedge clk);
    exp_tt = e; start[s] = 1'b1;
    push(s, t, m, p);
    @(posedge clk); #1; start[s] = 1'b0;
    if (walk) begin
      for (int k = 0; k < 8; k++)
        for (int h = 0; h <= sv(s); h++) begin
          if (k != 0 || h != 0) begin @(posedge clk); #1; end
          chk("vector", int'({a[s], b[s], c[s]}), k);
        end
    end
    drain();
  endtask

  task automatic wait_vec(input int s, input int v);
    int w = 0;
    while (int'({a[s], b[s], c[s]}) != v && w < 100) begin @(posedge clk); #1; w++; end
    chk("reach_vector", (w < 100) ? 1 : 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = '0; exp_tt = 8'h00; fmode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tt", int'(tt[0]), 0);
    chk("rst_mc", int'(mc[0]), 0);
    chk("rst_pass", int'(pass[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_abc", int'({a[0], b[0], c[0]}), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // parity model, matching expectation
    run_scan(0, 8'h96, 8'h96, 4'd0, 1'b1, 1'b1);
    #1;
    chk("abc_hold_7", int'({a[0], b[0], c[0]}), 7);
    chk("idle_busy", int'(busy[0]), 0);
    chk("idle_tt_hold", int'(tt[0]), 8'h96);

    // one expected bit wrong (vector 0)
    run_scan(0, 8'h97, 8'h96, 4'd1, 1'b0, 1'b0);

    // stuck-at-0 function against all-ones expectation
    fmode = 1'b1;
    run_scan(0, 8'hFF, 8'h00, 4'd8, 1'b0, 1'b0);
    fmode = 1'b0;

    // other settle values
    run_scan(1, 8'h96, 8'h96, 4'd0, 1'b1, 1'b1);
    run_scan(2, 8'h96, 8'h96, 4'd0, 1'b1, 1'b1);

    // start while busy, with a changed expectation: ignored
    @(negedge clk);
    exp_tt = 8'h96; start[0] = 1'b1;
    push(0, 8'h96, 4'd0, 1'b1);
    @(posedge clk); #1; start[0] = 1'b0;
    wait_vec(0, 3);
    @(negedge clk); exp_tt = 8'h00; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    chk("busy_mid_scan", int'(busy[0]), 1);
    drain();

    // reset mid-scan, then a clean scan
    @(negedge clk);
    exp_tt = 8'h96; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    wait_vec(0, 5);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_tt", int'(tt[0]), 0);
    chk("mid_rst_abc", int'({a[0], b[0], c[0]}), 0);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_done", int'(done[0]), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);      // no stray done may appear here
    run_scan(0, 8'h96, 8'h96, 4'd0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
